// File: rtl/key_action_queue_if.sv
// key_action_queue_if
//   Action stream between the key action queue (master) and the game FSM
//   (slave).
//
//   Handshake: act_valid is high whenever an action is offered. act_code
//   carries the head action and holds steady while act_valid=1 and
//   act_ready=0. A transfer happens on a clock edge where both act_valid and
//   act_ready are high. act_ready has no effect while act_valid is low.
//
//   Signals:
//     act_valid  master->slave  an action is available
//     act_ready  slave->master  consumer takes the head action this cycle
//     act_code   master->slave  head action code (0 when nothing is offered)
interface key_action_queue_if;
    logic       act_valid;
    logic       act_ready;
    logic [2:0] act_code;

    modport master (output act_valid, output act_code, input act_ready);
    modport slave  (input act_valid, input act_code, output act_ready);
endinterface

// File: rtl/key_action_queue.sv
// key_action_queue
//   Consumes keyboard decoder events, suppresses typematic auto-repeat with a
//   per-key hold mask, maps six scan codes to game actions and buffers the
//   actions in a small circular FIFO drained over a valid/ready stream.
//
//   Ports:
//     clk          system clock (decoder domain)
//     rst          asynchronous, active-high reset
//     key_down     decoder key-state vector, indexed by {extend, code}
//     last_change  {extend, code} of the most recent decoder event
//     key_valid    one-cycle event pulse; key_down already reflects it
//     act          action stream (master side): act_valid, act_ready, act_code
//     duck_held    down-arrow held, taken from the filtered hold mask
//     overflow     sticky flag: an action was dropped on a full FIFO
//     level        current FIFO occupancy
module key_action_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [511:0]             key_down,
    input  logic [8:0]               last_change,
    input  logic                     key_valid,
    key_action_queue_if.master       act,
    output logic                     duck_held,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Scan codes as {extend, code}.
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_R     = 9'h02D;
    localparam logic [8:0] KEY_P     = 9'h04D;

    // Hold-mask bit positions.
    localparam logic [2:0] BIT_SPACE = 3'd0;
    localparam logic [2:0] BIT_UP    = 3'd1;
    localparam logic [2:0] BIT_DOWN  = 3'd2;
    localparam logic [2:0] BIT_ENTER = 3'd3;
    localparam logic [2:0] BIT_R     = 3'd4;
    localparam logic [2:0] BIT_P     = 3'd5;

    // Action codes.
    localparam logic [2:0] ACT_NONE     = 3'd0;
    localparam logic [2:0] ACT_JUMP     = 3'd1;
    localparam logic [2:0] ACT_DUCK_ON  = 3'd2;
    localparam logic [2:0] ACT_DUCK_OFF = 3'd3;
    localparam logic [2:0] ACT_START    = 3'd4;
    localparam logic [2:0] ACT_RESTART  = 3'd5;
    localparam logic [2:0] ACT_PAUSE    = 3'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [5:0]       hold_q,     hold_d;
    logic [2:0]       mem_q [DEPTH];
    logic [2:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Scan-code decode
    // ------------------------------------------------------------------
    logic       map_hit;
    logic [2:0] map_bit;
    logic [2:0] map_press_act;

    always_comb begin
        map_hit       = 1'b0;
        map_bit       = BIT_SPACE;
        map_press_act = ACT_NONE;
        case (last_change)
            KEY_SPACE: begin map_hit = 1'b1; map_bit = BIT_SPACE; map_press_act = ACT_JUMP;    end
            KEY_UP:    begin map_hit = 1'b1; map_bit = BIT_UP;    map_press_act = ACT_JUMP;    end
            KEY_DOWN:  begin map_hit = 1'b1; map_bit = BIT_DOWN;  map_press_act = ACT_DUCK_ON; end
            KEY_ENTER: begin map_hit = 1'b1; map_bit = BIT_ENTER; map_press_act = ACT_START;   end
            KEY_R:     begin map_hit = 1'b1; map_bit = BIT_R;     map_press_act = ACT_RESTART; end
            KEY_P:     begin map_hit = 1'b1; map_bit = BIT_P;     map_press_act = ACT_PAUSE;   end
            default:   ;
        endcase
    end

    // ------------------------------------------------------------------
    // Auto-repeat filter and action generation
    // ------------------------------------------------------------------
    // The hold bit distinguishes a genuine press from typematic repeats: the
    // decoder re-reports a held key as another press, but the hold bit is
    // already set so nothing is generated. The mask updates even when the
    // resulting action is later dropped on a full FIFO, so the mask always
    // tracks the physical key state.
    logic       key_pressed;
    logic       push;
    logic [2:0] push_code;

    assign key_pressed = key_down[last_change];

    always_comb begin
        hold_d    = hold_q;
        push      = 1'b0;
        push_code = ACT_NONE;
        if (key_valid && map_hit) begin
            if (key_pressed && !hold_q[map_bit]) begin
                hold_d[map_bit] = 1'b1;
                push            = 1'b1;
                push_code       = map_press_act;
            end else if (!key_pressed && hold_q[map_bit]) begin
                hold_d[map_bit] = 1'b0;
                if (map_bit == BIT_DOWN) begin
                    push      = 1'b1;
                    push_code = ACT_DUCK_OFF;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Circular FIFO
    // ------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_ok;
    logic drop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign pop        = !fifo_empty && act.act_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_code;
            // DEPTH is a power of two, so the natural wrap is modulo DEPTH.
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ACT_NONE;
            end
        end else begin
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign act.act_valid = !fifo_empty;
    assign act.act_code  = fifo_empty ? ACT_NONE : mem_q[rd_ptr_q];
    assign level         = count_q;
    assign duck_held     = hold_q[BIT_DOWN];
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_key_action_queue.sv
module tb_key_action_queue;

  localparam int DEPTH = 4;

  localparam logic [8:0] K_SPACE = 9'h029;
  localparam logic [8:0] K_UP    = 9'h175;
  localparam logic [8:0] K_DOWN  = 9'h172;
  localparam logic [8:0] K_ENTER = 9'h05A;
  localparam logic [8:0] K_R     = 9'h02D;
  localparam logic [8:0] K_P     = 9'h04D;
  localparam logic [8:0] K_OTHER = 9'h01C;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         key_valid = 1'b0;
  logic         duck_held;
  logic         overflow;
  logic [2:0]   level;

  key_action_queue_if act_if ();

  always #5 clk = ~clk;

  key_action_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_down   (key_down),
    .last_change(last_change),
    .key_valid  (key_valid),
    .act        (act_if),
    .duck_held  (duck_held),
    .overflow   (overflow),
    .level      (level)
  );

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Pop the head against the scoreboard; called at a negedge.
  task automatic pop_head(input string name);
    chk({name, "_valid"}, int'(act_if.act_valid), 1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb_empty got pop want none", name);
    end else begin
      chk({name, "_code"}, int'(act_if.act_code), int'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver tasks ----------------
  // One decoder event; exp_act (nonzero) is appended to the scoreboard.
  task automatic send(input logic [8:0] code, input logic p, input logic rdy,
                      input logic [2:0] exp_act);
    key_down[code] = p;
    last_change    = code;
    key_valid      = 1'b1;
    act_if.act_ready = rdy;
    if (rdy) pop_head("evpop");
    if (exp_act != 3'd0) exp_q.push_back(exp_act);
    @(negedge clk);
    key_valid        = 1'b0;
    act_if.act_ready = 1'b0;
  endtask

  task automatic pop_one();
    pop_head("pop");
    act_if.act_ready = 1'b1;
    @(negedge clk);
    act_if.act_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) pop_one();
    chk({name, "_empty_valid"}, int'(act_if.act_valid), 0);
    chk({name, "_empty_code"}, int'(act_if.act_code), 0);
    chk({name, "_empty_level"}, int'(level), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [8:0] code;
    logic       press;
    logic       rdy;
    logic [2:0] act;
    int         lvl;
    logic       duck;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{K_SPACE, 1'b1, 1'b0, 3'd1, 1, 1'b0};  // genuine press
    vecs[1]  = '{K_SPACE, 1'b1, 1'b0, 3'd0, 1, 1'b0};  // auto-repeat
    vecs[2]  = '{K_SPACE, 1'b1, 1'b0, 3'd0, 1, 1'b0};
    vecs[3]  = '{K_SPACE, 1'b1, 1'b0, 3'd0, 1, 1'b0};
    vecs[4]  = '{K_SPACE, 1'b0, 1'b0, 3'd0, 1, 1'b0};  // release
    vecs[5]  = '{K_SPACE, 1'b1, 1'b0, 3'd1, 2, 1'b0};  // press again
    vecs[6]  = '{K_SPACE, 1'b0, 1'b0, 3'd0, 2, 1'b0};
    vecs[7]  = '{K_OTHER, 1'b1, 1'b0, 3'd0, 2, 1'b0};  // unmapped
    vecs[8]  = '{K_OTHER, 1'b0, 1'b0, 3'd0, 2, 1'b0};
    vecs[9]  = '{K_DOWN,  1'b0, 1'b0, 3'd0, 2, 1'b0};  // spurious release
    vecs[10] = '{K_DOWN,  1'b1, 1'b0, 3'd2, 3, 1'b1};  // DUCK_ON
    vecs[11] = '{K_DOWN,  1'b1, 1'b0, 3'd0, 3, 1'b1};  // repeat
    vecs[12] = '{K_DOWN,  1'b0, 1'b0, 3'd3, 4, 1'b0};  // DUCK_OFF, now full
    vecs[13] = '{K_UP,    1'b1, 1'b1, 3'd1, 4, 1'b0};  // full push+pop
    vecs[14] = '{K_UP,    1'b0, 1'b1, 3'd0, 3, 1'b0};  // pop only
    vecs[15] = '{K_ENTER, 1'b1, 1'b0, 3'd4, 4, 1'b0};

    // reset
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    act_if.act_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(act_if.act_valid), 0);
    chk("rst_code", int'(act_if.act_code), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_duck", int'(duck_held), 0);
    chk("rst_overflow", int'(overflow), 0);

    // table-driven events
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].code, vecs[i].press, vecs[i].rdy, vecs[i].act);
      chk($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
      chk($sformatf("vec%0d_duck", i), int'(duck_held), int'(vecs[i].duck));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), 0);
    end
    // pop order should be 2,3,1(UP, wrapped),4
    send(K_ENTER, 1'b0, 1'b0, 3'd0);
    drain("tbl");

    // overflow: five distinct presses with consumer stalled
    send(K_ENTER, 1'b1, 1'b0, 3'd4);
    send(K_R,     1'b1, 1'b0, 3'd5);
    send(K_P,     1'b1, 1'b0, 3'd6);
    send(K_SPACE, 1'b1, 1'b0, 3'd1);
    chk("ovf_pre_flag", int'(overflow), 0);
    send(K_UP,    1'b1, 1'b0, 3'd0);  // dropped
    chk("ovf_level", int'(level), 4);
    chk("ovf_flag", int'(overflow), 1);
    drain("ovf");
    chk("ovf_sticky", int'(overflow), 1);
    send(K_UP, 1'b1, 1'b0, 3'd0);     // hold bit still set
    chk("ovf_up_held_level", int'(level), 0);
    send(K_UP, 1'b0, 1'b0, 3'd0);
    chk("ovf_up_rel_level", int'(level), 0);
    send(K_UP, 1'b1, 1'b0, 3'd1);
    chk("ovf_up_again_level", int'(level), 1);
    drain("ovf_up");
    send(K_UP,    1'b0, 1'b0, 3'd0);
    send(K_ENTER, 1'b0, 1'b0, 3'd0);
    send(K_R,     1'b0, 1'b0, 3'd0);
    send(K_P,     1'b0, 1'b0, 3'd0);
    send(K_SPACE, 1'b0, 1'b0, 3'd0);
    chk("rel_level", int'(level), 0);

    // asynchronous reset mid-clock with 3 queued and DOWN held
    send(K_DOWN,  1'b1, 1'b0, 3'd2);
    send(K_SPACE, 1'b1, 1'b0, 3'd1);
    send(K_R,     1'b1, 1'b0, 3'd5);
    chk("arst_pre_level", int'(level), 3);
    chk("arst_pre_duck", int'(duck_held), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(act_if.act_valid), 0);
    chk("arst_code", int'(act_if.act_code), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_duck", int'(duck_held), 0);
    chk("arst_overflow", int'(overflow), 0);
    exp_q.delete();
    key_down = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // hold mask cleared by reset: a fresh press works
    send(K_SPACE, 1'b1, 1'b0, 3'd1);
    chk("post_level", int'(level), 1);
    drain("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_action_queue.md
# key_action_queue

Downstream consumer of the keyboard decoder. Watches the decoder's per-event pulse, filters typematic auto-repeat, maps a fixed set of scan codes to game actions, and buffers them in a small FIFO. The game FSM pops the actions with a valid/ready handshake. Also exports a level signal for the duck key.

## Interface

- DEPTH, 4: FIFO entries; power of two, 2..16.
- clk  in  1  system clock, same domain as the decoder.
- rst  in  1  asynchronous, active-high reset.
- key_down  in  512  decoder key-state vector, indexed by {extend, code}.
- last_change  in  9  {extend, code} of the most recent decoder event.
- key_valid  in  1  one-cycle decoder event pulse. key_down already reflects the event in the same cycle.
- act_ready  in  1  consumer accepts the head action this cycle.
- act_valid  out  1  FIFO non-empty.
- act_code  out  3  head action code; 0 when empty.
- duck_held  out  1  down-arrow currently held (filtered copy).
- overflow  out  1  sticky: an action was dropped because the FIFO was full.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation

- Mapped keys and their hold-mask bits:
  - SPACE 9'h029 (bit 0)
  - UP 9'h175 (bit 1)
  - DOWN 9'h172 (bit 2)
  - ENTER 9'h05A (bit 3)
  - R 9'h02D (bit 4)
  - P 9'h04D (bit 5)
- Any other last_change value is ignored: no action, no mask change.
- On key_valid with a mapped code, let p = key_down[last_change] (1 = press, 0 = release) and h = the key's hold bit.
  - p=1, h=0: genuine press. Set h and generate the press action.
  - p=1, h=1: auto-repeat. No action; h stays 1.
  - p=0, h=1: release. Clear h. Generate an action only for DOWN.
  - p=0, h=0: spurious release. Ignored.
- Action codes:
  - JUMP=1: SPACE or UP press.
  - DUCK_ON=2: DOWN press.
  - DUCK_OFF=3: DOWN release.
  - START=4: ENTER press.
  - RESTART=5: R press.
  - PAUSE=6: P press.
  - 0 and 7 are never produced.
- The hold mask updates on every mapped event, including events whose action is dropped. duck_held = mask bit 2.
- FIFO: circular buffer with wr_ptr, rd_ptr and count, all width-correct and wrapping modulo DEPTH.
  - push = generated action.
  - pop = act_valid && act_ready.
  - Push when count==DEPTH with no pop in the same cycle: action dropped, overflow set to 1. overflow clears only on reset.
  - Push and pop in the same cycle when full: both succeed; count unchanged; no overflow.
  - Push and pop in the same cycle when non-full and non-empty: count unchanged.
  - Pop when empty: impossible by construction (act_valid=0). act_ready is ignored.
- act_code is driven from the head entry register, or 0 when count==0. The head is stable while act_valid=1 and act_ready=0.
- Reset values: hold mask 0, FIFO pointers and count 0, act_valid 0, act_code 0, duck_held 0, overflow 0, level 0.
- Reset asserted mid-operation discards all queued actions and held state immediately (asynchronous).

## Timing

- Latency: key_valid in cycle N produces, at the clk edge ending N, the mask update and the push. act_valid/level/duck_held reflect it in cycle N+1.
- Pop on the edge ending cycle M. The next entry (or act_valid=0) is visible in cycle M+1.
- Fully synchronous except reset. One event per cycle maximum; key_valid pulses are at least one cycle apart.
- Throughput: one push and one pop per cycle.

## Test plan

- Reset, then SPACE press (key_down[9'h029]=1, key_valid pulse):
  - act_valid=1, act_code=1, level=1 one cycle later.
  - act_ready=1 for one cycle empties the FIFO: act_valid=0, act_code=0.
- Auto-repeat: SPACE press, then three more SPACE key_valid pulses with key_down still 1, then release:
  - Exactly one JUMP queued.
  - A second press after the release queues another JUMP.
- Duck: DOWN press, then DOWN release:
  - Queue holds 2 then 3.
  - duck_held=1 between the events, 0 after.
  - UP (9'h175) press queues 1; key 9'h01C press queues nothing.
- Overflow (DEPTH=4, act_ready=0): 5 distinct presses ENTER, R, P, SPACE, UP:
  - level=4 and overflow=1.
  - Popping yields 4,5,6,1; the UP JUMP is absent.
  - UP's hold bit is still set: repeated UP produces nothing until it is released.
- Full with simultaneous push and pop: fill 4 entries, then a press with act_ready=1 in the same cycle:
  - level stays 4, overflow stays 0.
  - The new action is last in pop order, confirming pointer wrap.
- Asynchronous reset asserted mid-clock with 3 entries queued and DOWN held:
  - Immediately act_valid=0, level=0, duck_held=0, overflow=0.
